rv32_dmem: RTL and testbench

RV32_DMEM -- requirements
Module: rv32_dmem

---
 rtl/rv32_dmem_pkg.sv | 46 ++++
 rtl/rv32_dmem_if.sv | 29 ++
 rtl/rv32_dmem_con_fifo.sv | 61 ++++++
 rtl/rv32_dmem.sv | 123 ++++++++++++
 tb/tb_rv32_dmem.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32_dmem_pkg : access-size codes, console default and load formatter    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package rv32_dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [31:0] CON_ADDR_DEFAULT = 32'hFFFF_0000;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_CON  = 2'd2
  } rd_sel_e;

  // Misaligned LH/LHU/LW return zero rather than faulting.
  function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                           input logic [1:0]  lo,
                                           input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LBU:  r = {24'd0, b};
      F3_LH:   r = lo[0] ? 32'd0 : {{16{h[15]}}, h};
      F3_LHU:  r = lo[0] ? 32'd0 : {16'd0, h};
      F3_LW:   r = (lo != 2'd0) ? 32'd0 : word;
      default: r = word;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_dmem_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32_dmem_if : core data-bus and console signals of the data memory      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface rv32_dmem_if;
  logic [31:0] dmAddress;
  logic [2:0]  dmFunc3;
  logic        dmWrite;
  logic [31:0] dmDataOut;
  logic [31:0] dmDataIn;
  logic [7:0]  conTxData;
  logic        conTxValid;
  logic        conTxReady;
  logic        wrFault;
  logic [31:0] wrFaultAddr;
  logic        conOverflow;

  modport master (
    output dmAddress, dmFunc3, dmWrite, dmDataOut, conTxReady,
    input  dmDataIn, conTxData, conTxValid, wrFault, wrFaultAddr, conOverflow
  );

  modport slave (
    input  dmAddress, dmFunc3, dmWrite, dmDataOut, conTxReady,
    output dmDataIn, conTxData, conTxValid, wrFault, wrFaultAddr, conOverflow
  );
endinterface
`default_nettype wire

// File: rtl/rv32_dmem_con_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | con_fifo : 4-entry console byte FIFO with sticky overflow flag           |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module con_fifo
  import rv32_dmem_pkg::*;
(
  input  wire logic       clock,
  input  wire logic       reset,
  input  wire logic       push_i,
  input  wire logic [7:0] din_i,
  input  wire logic       pop_i,
  output logic      [7:0] dout_o,
  output logic            valid_o,
  output logic      [2:0] count_o,
  output logic            overflow_o
);

  logic [7:0] buf_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       overflow_q, overflow_d;
  logic       pop_en, push_en;

  // A full FIFO still accepts a push when a pop frees a slot at the same edge.
  always_comb begin
    pop_en     = pop_i && (count_q != 3'd0);
    push_en    = push_i && ((count_q != 3'd4) || pop_en);
    wr_ptr_d   = push_en ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d   = pop_en ? rd_ptr_q + 2'd1 : rd_ptr_q;
    count_d    = count_q + {2'b00, push_en} - {2'b00, pop_en};
    overflow_d = overflow_q || (push_i && !push_en);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) buf_q[wr_ptr_q] <= din_i;
  end

  assign valid_o    = (count_q != 3'd0);
  assign dout_o     = valid_o ? buf_q[rd_ptr_q] : 8'd0;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: rtl/rv32_dmem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32_dmem : byte-enabled data RAM with registered read and console MMIO  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module rv32_dmem
  import rv32_dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] CON_ADDR    = CON_ADDR_DEFAULT
) (
  input wire logic   clock,
  input wire logic   reset,
  rv32_dmem_if.slave bus
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

  logic [31:0] ram_q [DEPTH_WORDS];
  logic [31:0] rword_q;
  logic [1:0]  lo_q;
  logic [2:0]  f3_q;
  logic [2:0]  cnt_q;
  rd_sel_e     sel_q, sel_d;
  logic        wrFault_q, wrFault_d;
  logic [31:0] faddr_q, faddr_d;

  logic [31:0] con_off;
  logic        in_mmio, is_con, is_ram, mis_st, ram_we, con_push;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [2:0]  con_count;
  logic [AW-1:0] widx;

  assign widx = bus.dmAddress[AW+1:2];

  always_comb begin
    con_off = bus.dmAddress - CON_ADDR;
    in_mmio = (con_off[31:4] == 28'd0);
    is_con  = in_mmio && (con_off[3:0] == 4'd0);
    is_ram  = !in_mmio && (bus.dmAddress[31:2] < DEPTH_W);
    mis_st  = ((bus.dmFunc3 == F3_SH) && bus.dmAddress[0]) ||
              ((bus.dmFunc3 == F3_SW) && (bus.dmAddress[1:0] != 2'd0));
    be    = 4'b0000;
    wdata = bus.dmDataOut;
    case (bus.dmFunc3)
      F3_SB: begin
        be    = 4'b0001 << bus.dmAddress[1:0];
        wdata = {4{bus.dmDataOut[7:0]}};
      end
      F3_SH: begin
        be    = bus.dmAddress[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.dmDataOut[15:0]}};
      end
      F3_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    // A store coinciding with reset is discarded.
    ram_we   = bus.dmWrite && is_ram && !mis_st && !reset;
    con_push = bus.dmWrite && is_con;
    sel_d    = is_con ? SEL_CON : (is_ram ? SEL_RAM : SEL_NONE);
    wrFault_d = wrFault_q;
    faddr_d   = faddr_q;
    if (bus.dmWrite && !in_mmio && mis_st && !wrFault_q) begin
      wrFault_d = 1'b1;
      faddr_d   = bus.dmAddress;
    end
  end

  // Read-first RAM: the registered word holds the pre-write contents.
  always_ff @(posedge clock) begin
    rword_q <= ram_q[widx];
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram_q[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_q     <= SEL_NONE;
      lo_q      <= 2'd0;
      f3_q      <= 3'd0;
      cnt_q     <= 3'd0;
      wrFault_q <= 1'b0;
      faddr_q   <= 32'd0;
    end else begin
      sel_q     <= sel_d;
      lo_q      <= bus.dmAddress[1:0];
      f3_q      <= bus.dmFunc3;
      cnt_q     <= con_count;
      wrFault_q <= wrFault_d;
      faddr_q   <= faddr_d;
    end
  end

  always_comb begin
    case (sel_q)
      SEL_RAM: bus.dmDataIn = fmt_load(rword_q, lo_q, f3_q);
      SEL_CON: bus.dmDataIn = {29'd0, cnt_q};
      default: bus.dmDataIn = 32'd0;
    endcase
  end

  assign bus.wrFault     = wrFault_q;
  assign bus.wrFaultAddr = faddr_q;

  con_fifo u_con_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (con_push),
    .din_i      (bus.dmDataOut[7:0]),
    .pop_i      (bus.conTxReady),
    .dout_o     (bus.conTxData),
    .valid_o    (bus.conTxValid),
    .count_o    (con_count),
    .overflow_o (bus.conOverflow)
  );

endmodule
`default_nettype wire

// File: tb/tb_rv32_dmem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rv32_dmem : vector table, corner sequences and random model checking  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_rv32_dmem;
  import rv32_dmem_pkg::*;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] CON   = 32'hFFFF_0000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rv32_dmem_if bus();

  rv32_dmem #(.DEPTH_WORDS(DEPTH), .CON_ADDR(CON)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference state: byte-addressed RAM image, console queue, sticky flags.
  logic [7:0]  mb [DEPTH*4];
  logic [7:0]  fq [$];
  logic        m_fault, m_ovf;
  logic [31:0] m_faddr;

  typedef struct {
    logic [31:0] a;
    logic [2:0]  f;
    logic        w;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [23];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f);
    logic signed [31:0] v;
    logic [11:0] i;
    i = a[11:0];
    if (a == CON) return {29'd0, 3'(fq.size())};
    if ((a - CON) < 32'd16) return 32'd0;
    if (a >= 32'(DEPTH*4)) return 32'd0;
    case (f)
      3'd0: begin v = $signed(mb[i]); return v; end
      3'd4: return {24'd0, mb[i]};
      3'd1: begin
        if (a[0]) return 32'd0;
        v = $signed({mb[i+12'd1], mb[i]});
        return v;
      end
      3'd5: return a[0] ? 32'd0 : {16'd0, mb[i+12'd1], mb[i]};
      3'd2: if (a[1:0] != 2'd0) return 32'd0;
      default: ;
    endcase
    i = {a[11:2], 2'b00};
    return {mb[i+12'd3], mb[i+12'd2], mb[i+12'd1], mb[i]};
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    logic [11:0] i;
    i = a[11:0];
    if ((a - CON) < 32'd16) return;
    if ((f == 3'd1 && a[0]) || (f == 3'd2 && a[1:0] != 2'd0)) begin
      if (!m_fault) begin
        m_fault = 1'b1;
        m_faddr = a;
      end
      return;
    end
    if (a >= 32'(DEPTH*4)) return;
    for (int k = 0; k < (f == 3'd0 ? 1 : f == 3'd1 ? 2 : f == 3'd2 ? 4 : 0); k++)
      mb[i + 12'(k)] = d[8*k +: 8];
  endtask

  task automatic check_state();
    check("conTxValid", {31'd0, bus.conTxValid}, {31'd0, fq.size() != 0});
    if (fq.size() != 0) check("conTxData", {24'd0, bus.conTxData}, {24'd0, fq[0]});
    check("wrFault", {31'd0, bus.wrFault}, {31'd0, m_fault});
    check("wrFaultAddr", bus.wrFaultAddr, m_faddr);
    check("conOverflow", {31'd0, bus.conOverflow}, {31'd0, m_ovf});
  endtask

  task automatic cyc(input logic [31:0] a, input logic [2:0] f, input logic w,
                     input logic [31:0] d, input logic rdy, input logic ck,
                     output logic [31:0] got);
    logic [31:0] exp;
    logic        popping;
    int          sz;
    bus.dmAddress  = a;
    bus.dmFunc3    = f;
    bus.dmWrite    = w;
    bus.dmDataOut  = d;
    bus.conTxReady = rdy;
    exp     = model_load(a, f);
    sz      = fq.size();
    popping = rdy && (sz > 0);
    @(posedge clock);
    #1;
    if (popping) void'(fq.pop_front());
    if (w && a == CON) begin
      if (sz == 4 && !popping) m_ovf = 1'b1;
      else fq.push_back(d[7:0]);
    end else if (w) begin
      model_store(a, f, d);
    end
    got = bus.dmDataIn;
    if (ck) check("dmDataIn", got, exp);
    check_state();
  endtask

  task automatic model_reset();
    fq.delete();
    m_fault = 1'b0;
    m_ovf   = 1'b0;
    m_faddr = 32'd0;
  endtask

  task automatic drain_check(input string tag, input string s);
    logic [7:0]  seen [$];
    logic [31:0] got;
    for (int k = 0; k < 6; k++) begin
      if (bus.conTxValid) seen.push_back(bus.conTxData);
      cyc(32'h0, F3_LW, 1'b0, 32'h0, 1'b1, 1'b1, got);
    end
    check({tag, "_count"}, 32'(seen.size()), 32'(s.len()));
    for (int k = 0; k < s.len() && k < seen.size(); k++)
      check({tag, "_byte"}, {24'd0, seen[k]}, {24'd0, s[k]});
    check({tag, "_empty"}, {31'd0, bus.conTxValid}, 32'd0);
  endtask

  initial begin
    logic [31:0] got, a;
    string       s;
    int          r;

    for (int k = 0; k < DEPTH*4; k++) mb[k] = 8'd0;
    model_reset();
    reset          = 1'b1;
    bus.dmAddress  = 32'h0;
    bus.dmFunc3    = F3_LW;
    bus.dmWrite    = 1'b0;
    bus.dmDataOut  = 32'h0;
    bus.conTxReady = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_dmDataIn", bus.dmDataIn, 32'd0);
    check("rst_conTxData", {24'd0, bus.conTxData}, 32'd0);
    check_state();
    reset = 1'b0;

    // Give the low RAM a known image so every later read is model-exact.
    for (int k = 0; k < 64; k++)
      cyc(32'(4*k), F3_SW, 1'b1, 32'h0, 1'b0, 1'b0, got);

    tbl[0]  = '{32'h10, F3_SW,  1'b1, 32'hDEADBEEF, 32'h00000000};
    tbl[1]  = '{32'h10, F3_LW,  1'b0, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{32'h13, F3_SB,  1'b1, 32'h80,       32'hFFFFFFDE};
    tbl[3]  = '{32'h13, F3_LB,  1'b0, 32'h0,        32'hFFFFFF80};
    tbl[4]  = '{32'h13, F3_LBU, 1'b0, 32'h0,        32'h00000080};
    tbl[5]  = '{32'h10, F3_LW,  1'b0, 32'h0,        32'h80ADBEEF};
    tbl[6]  = '{32'h12, F3_SH,  1'b1, 32'h8001,     32'hFFFF80AD};
    tbl[7]  = '{32'h12, F3_LH,  1'b0, 32'h0,        32'hFFFF8001};
    tbl[8]  = '{32'h12, F3_LHU, 1'b0, 32'h0,        32'h00008001};
    tbl[9]  = '{32'h10, F3_LW,  1'b0, 32'h0,        32'h8001BEEF};
    tbl[10] = '{32'h11, F3_LW,  1'b0, 32'h0,        32'h00000000};
    tbl[11] = '{32'h13, F3_LH,  1'b0, 32'h0,        32'h00000000};
    tbl[12] = '{32'h11, F3_LB,  1'b0, 32'h0,        32'hFFFFFFBE};
    tbl[13] = '{32'h12, F3_LBU, 1'b0, 32'h0,        32'h00000001};
    tbl[14] = '{32'h10, 3'd3,   1'b0, 32'h0,        32'h8001BEEF};
    tbl[15] = '{32'h10, 3'd4,   1'b1, 32'hFFFFFFFF, 32'h000000EF};
    tbl[16] = '{32'h10, F3_LW,  1'b0, 32'h0,        32'h8001BEEF};
    tbl[17] = '{32'h0,  F3_SW,  1'b1, 32'h11111111, 32'h00000000};
    tbl[18] = '{32'h1000, F3_SW, 1'b1, 32'h12345678, 32'h00000000};
    tbl[19] = '{32'h1000, F3_LW, 1'b0, 32'h0,       32'h00000000};
    tbl[20] = '{32'h0,  F3_LW,  1'b0, 32'h0,        32'h11111111};
    tbl[21] = '{CON + 32'd4, F3_SW, 1'b1, 32'h55,   32'h00000000};
    tbl[22] = '{CON,    F3_LW,  1'b0, 32'h0,        32'h00000000};
    for (int k = 0; k < 23; k++) begin
      cyc(tbl[k].a, tbl[k].f, tbl[k].w, tbl[k].d, 1'b0, 1'b1, got);
      check($sformatf("vec%0d", k), got, tbl[k].exp);
    end

    // Misaligned stores: first fault address is kept.
    cyc(32'h20, F3_SW, 1'b1, 32'h55AA55AA, 1'b0, 1'b1, got);
    cyc(32'h21, F3_SW, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1, got);
    check("fault_set", {31'd0, bus.wrFault}, 32'd1);
    check("fault_addr", bus.wrFaultAddr, 32'h21);
    cyc(32'h20, F3_LW, 1'b0, 32'h0, 1'b0, 1'b1, got);
    check("mis_sw_nowrite", got, 32'h55AA55AA);
    cyc(32'h33, F3_SH, 1'b1, 32'h1234, 1'b0, 1'b1, got);
    check("fault_addr_kept", bus.wrFaultAddr, 32'h21);
    cyc(32'h30, F3_LW, 1'b0, 32'h0, 1'b0, 1'b1, got);

    // Console fill past capacity, then drain.
    s = "ABCDE";
    for (int k = 0; k < 5; k++) cyc(CON, F3_SB, 1'b1, 32'(s[k]), 1'b0, 1'b1, got);
    check("con_ovf", {31'd0, bus.conOverflow}, 32'd1);
    cyc(CON, F3_LW, 1'b0, 32'h0, 1'b0, 1'b1, got);
    check("con_count4", got, 32'd4);
    drain_check("drain1", "ABCD");

    // Reset in the middle of a drain, with a store held across the reset edge.
    s = "PQR";
    for (int k = 0; k < 3; k++) cyc(CON, F3_SB, 1'b1, 32'(s[k]), 1'b0, 1'b1, got);
    cyc(32'h10, F3_LW, 1'b0, 32'h0, 1'b1, 1'b1, got);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check("arst_valid", {31'd0, bus.conTxValid}, 32'd0);
    check("arst_dmDataIn", bus.dmDataIn, 32'd0);
    check("arst_ovf", {31'd0, bus.conOverflow}, 32'd0);
    check("arst_fault", {31'd0, bus.wrFault}, 32'd0);
    bus.dmAddress = 32'h10;
    bus.dmFunc3   = F3_SW;
    bus.dmWrite   = 1'b1;
    bus.dmDataOut = 32'hBAD0BAD0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc(32'h10, F3_LW, 1'b0, 32'h0, 1'b0, 1'b1, got);
    check("ram_kept", got, 32'h8001BEEF);

    // Push and pop together while full.
    s = "WXYZ";
    for (int k = 0; k < 4; k++) cyc(CON, F3_SB, 1'b1, 32'(s[k]), 1'b0, 1'b1, got);
    cyc(CON, F3_SW, 1'b1, 32'h51, 1'b1, 1'b1, got);
    check("pp_ovf", {31'd0, bus.conOverflow}, 32'd0);
    cyc(CON, F3_LW, 1'b0, 32'h0, 1'b0, 1'b1, got);
    check("pp_count4", got, 32'd4);
    drain_check("drain2", "XYZQ");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = $urandom_range(0, 255);
      else if (r < 9)  a = CON;
      else if ($urandom_range(0, 1) == 1) a = CON + 32'(4 * $urandom_range(1, 3));
      else             a = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      cyc(a, 3'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, $urandom,
          1'($urandom_range(0, 1)), 1'b1, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
